// File: rtl/proc_trace_buffer_pkg.sv
// Shared definitions for the processor trace buffer: word layout and FSM states.
package proc_trace_buffer_pkg;

    localparam int TRACE_W = 9;

    localparam int REG_LSB = 6;
    localparam int PC_LSB  = 4;
    localparam int ST_LSB  = 2;
    localparam int INS_LSB = 0;

    typedef enum logic [1:0] {
        TRC_IDLE    = 2'b00,
        TRC_CAPTURE = 2'b01,
        TRC_DONE    = 2'b10
    } trc_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; flush overrides push and pop.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push & ~do_pop) count_d = count_q + 1'b1;
            if (do_pop & ~do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/proc_trace_buffer.sv
// Observer stage: packs processor state into trace words and buffers them
// until the host drains them; capture stops on the processor halt state.
module proc_trace_buffer
    import proc_trace_buffer_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter logic [1:0] HALT_STATE = 2'b11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic [2:0]             registerCount,
    input  logic [1:0]             programCount,
    input  logic [1:0]             stateCount,
    input  logic [1:0]             instruction,
    input  logic                   arm,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [TRACE_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   capturing,
    output logic                   halted,
    output logic                   overflow
);

    trc_state_e       state_q, state_d;
    logic             halted_q, halted_d;
    logic             overflow_q, overflow_d;
    logic [TRACE_W-1:0] word;
    logic             arm_ok, push_req, pop_ok;
    logic             fifo_full, fifo_empty;

    always_comb begin
        word = '0;
        word[REG_LSB +: 3] = registerCount;
        word[PC_LSB  +: 2] = programCount;
        word[ST_LSB  +: 2] = stateCount;
        word[INS_LSB +: 2] = instruction;
    end

    assign arm_ok   = arm & (state_q != TRC_CAPTURE);
    assign push_req = (state_q == TRC_CAPTURE) & clk_en;
    assign pop_ok   = rd_valid & rd_ready & ~arm_ok;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        overflow_d = overflow_q;
        unique case (state_q)
            TRC_IDLE, TRC_DONE: begin
                if (arm) begin
                    state_d    = TRC_CAPTURE;
                    halted_d   = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            TRC_CAPTURE: begin
                if (push_req) begin
                    if (fifo_full & ~pop_ok) overflow_d = 1'b1;
                    if (word[ST_LSB +: 2] == HALT_STATE) begin
                        halted_d = 1'b1;
                        state_d  = TRC_DONE;
                    end
                end
            end
            default: state_d = TRC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TRC_IDLE;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(TRACE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (rd_valid & rd_ready),
        .flush (arm_ok),
        .din   (word),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rd_valid  = ~fifo_empty;
    assign capturing = (state_q == TRC_CAPTURE);
    assign halted    = halted_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Scoreboard bench for proc_trace_buffer: directed steps queue expected words,
// a negedge monitor checks every word the host pops.
module tb_proc_trace_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic [2:0] registerCount;
    logic [1:0] programCount;
    logic [1:0] stateCount;
    logic [1:0] instruction;
    logic       arm;
    logic       rd_ready;
    logic       rd_valid;
    logic [8:0] rd_data;
    logic [3:0] count;
    logic       capturing;
    logic       halted;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb[$];

    proc_trace_buffer #(.DEPTH(8), .HALT_STATE(2'b11)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .registerCount (registerCount),
        .programCount  (programCount),
        .stateCount    (stateCount),
        .instruction   (instruction),
        .arm           (arm),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .count         (count),
        .capturing     (capturing),
        .halted        (halted),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: a pop happens at the next edge whenever valid&ready with no flush.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!reset && rd_valid && rd_ready && !arm) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %b, required no word", rd_data);
            end else begin
                exp = sb.pop_front();
                if (rd_data !== exp) begin
                    fails++;
                    $display("FAIL pop_data: got %b, required %b", rd_data, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic logic [8:0] w(logic [2:0] r, logic [1:0] p, logic [1:0] s, logic [1:0] n);
        return {r, p, s, n};
    endfunction

    task automatic step(input logic [2:0] r, input logic [1:0] p, input logic [1:0] s,
                        input logic [1:0] n, input logic rdy);
        registerCount = r;
        programCount  = p;
        stateCount    = s;
        instruction   = n;
        clk_en        = 1'b1;
        rd_ready      = rdy;
        @(posedge clk);
        #1;
        clk_en   = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        clk_en   = 1'b0;
        rd_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    task automatic do_arm(input logic rdy);
        arm      = 1'b1;
        rd_ready = rdy;
        @(posedge clk);
        #1;
        arm      = 1'b0;
        rd_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        clk_en = 1'b0;
        registerCount = '0;
        programCount = '0;
        stateCount = '0;
        instruction = '0;
        arm = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_flags", 32'({capturing, halted, overflow}), 0);
        reset = 1'b0;

        // Idle: steps without arm capture nothing, even a halt-state word.
        registerCount = 3'd5;
        stateCount = 2'b11;
        idle(0, 1'b0);
        clk_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        clk_en = 1'b0;
        chk("idle_count", 32'(count), 0);
        chk("idle_valid", 32'(rd_valid), 0);
        chk("idle_capt", 32'(capturing), 0);
        chk("idle_halted", 32'(halted), 0);

        // Basic capture of three steps.
        do_arm(1'b0);
        chk("arm_capt", 32'(capturing), 1);
        sb.push_back(9'b001_00_01_10);
        step(3'd1, 2'd0, 2'b01, 2'b10, 1'b0);
        chk("fwft_data", 32'(rd_data), 32'(9'b001_00_01_10));
        sb.push_back(9'b010_01_01_10);
        step(3'd2, 2'd1, 2'b01, 2'b10, 1'b0);
        sb.push_back(9'b011_10_01_10);
        step(3'd3, 2'd2, 2'b01, 2'b10, 1'b0);
        chk("basic_count", 32'(count), 3);
        idle(3, 1'b1);
        chk("basic_drain", 32'(count), 0);
        chk("basic_sb", 32'(sb.size()), 0);
        chk("empty_data", 32'(rd_data), 0);

        // Halt on second step; later steps are ignored.
        sb.push_back(9'b100_01_01_00);
        step(3'd4, 2'd1, 2'b01, 2'b00, 1'b0);
        sb.push_back(9'b101_10_11_01);
        step(3'd5, 2'd2, 2'b11, 2'b01, 1'b0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_capt", 32'(capturing), 0);
        chk("halt_count", 32'(count), 2);
        repeat (3) step(3'd6, 2'd3, 2'b01, 2'b00, 1'b0);
        chk("halt_nomore", 32'(count), 2);
        chk("halt_head", 32'(rd_data), 32'(9'b100_01_01_00));

        // Re-arm from DONE with a pop requested: flush wins.
        do_arm(1'b1);
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(rd_valid), 0);
        chk("flush_halted", 32'(halted), 0);
        chk("flush_capt", 32'(capturing), 1);

        // Overflow: ten steps into an 8-deep FIFO, then a rejected halt word.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(w(3'(i), 2'(i), 2'b01, 2'(i >> 2)));
            step(3'(i), 2'(i), 2'b01, 2'(i >> 2), 1'b0);
        end
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_capt", 32'(capturing), 1);
        step(3'd7, 2'd3, 2'b11, 2'b11, 1'b0);
        chk("ovf_halt", 32'({halted, capturing}), 32'(2'b10));
        chk("ovf_count2", 32'(count), 8);
        idle(8, 1'b1);
        chk("ovf_drain", 32'(count), 0);
        chk("ovf_sb", 32'(sb.size()), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        do_arm(1'b0);
        chk("rearm_ovf", 32'(overflow), 0);
        chk("rearm_count", 32'(count), 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(w(3'(i), 2'(3 - i), 2'b01, 2'b01));
            step(3'(i), 2'(3 - i), 2'b01, 2'b01, 1'b0);
        end
        chk("full_count", 32'(count), 8);
        sb.push_back(9'b111_00_01_11);
        step(3'd7, 2'd0, 2'b01, 2'b11, 1'b1);
        chk("fullpop_count", 32'(count), 8);
        chk("fullpop_ovf", 32'(overflow), 0);
        idle(8, 1'b1);
        chk("fullpop_drain", 32'(count), 0);
        chk("fullpop_sb", 32'(sb.size()), 0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++) begin
            sb.push_back(w(3'(i + 2), 2'(i), 2'b10, 2'b10));
            step(3'(i + 2), 2'(i), 2'b10, 2'b10, 1'b0);
        end
        chk("pre_rst_count", 32'(count), 5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_capt", 32'(capturing), 0);
        chk("arst_data", 32'(rd_data), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(3'd1, 2'd1, 2'b01, 2'b01, 1'b0);
        chk("post_rst_idle", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
